// File: rtl/l2_cache_arbiter.sv
// Round-robin arbiter merging split L1 I/D line requests onto a single L2 port.
// One transaction in flight; request latched at grant, response returned as a one-cycle registered pulse.
module l2_cache_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LINE_W   = 128,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    DONE_I  = 3'd3,
    DONE_D  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [LINE_W-1:0]   req_wdata_q, req_wdata_d;
  logic                req_is_write_q, req_is_write_d;
  logic [LINE_W-1:0]   rbuf_q, rbuf_d;

  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d;
  logic                i_resp_q, i_resp_d;
  logic [LINE_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_resp_q, d_resp_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic                l2_read_q, l2_read_d;
  logic                l2_write_q, l2_write_d;
  logic [LINE_W-1:0]   l2_wdata_q, l2_wdata_d;

  logic i_pend, d_pend, grant_d, serving;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // Next state, latched request and registered outputs derived from the next state.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_is_write_d = req_is_write_q;
    rbuf_d         = rbuf_q;
    grant_d        = d_pend & (~i_pend | ~last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d        = SERVE_D;
          last_grant_d   = 1'b1;
          req_addr_d     = d_addr & ALIGN_MASK;
          req_wdata_d    = d_wdata;
          req_is_write_d = d_write;
        end else if (i_pend) begin
          state_d        = SERVE_I;
          last_grant_d   = 1'b0;
          req_addr_d     = i_addr & ALIGN_MASK;
          req_is_write_d = 1'b0;
        end
      end
      SERVE_I: begin
        if (l2_resp) begin
          rbuf_d  = l2_rdata;
          state_d = DONE_I;
        end
      end
      SERVE_D: begin
        if (l2_resp) begin
          rbuf_d  = l2_rdata;
          state_d = DONE_D;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    serving    = (state_d == SERVE_I) || (state_d == SERVE_D);
    l2_addr_d  = serving ? req_addr_d : '0;
    l2_wdata_d = serving ? req_wdata_d : '0;
    l2_read_d  = serving & ~req_is_write_d;
    l2_write_d = serving & req_is_write_d;
    i_resp_d   = (state_d == DONE_I);
    d_resp_d   = (state_d == DONE_D);
    i_rdata_d  = i_resp_d ? rbuf_d : '0;
    d_rdata_d  = d_resp_d ? rbuf_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_is_write_q <= 1'b0;
      rbuf_q         <= '0;
      i_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_rdata_q      <= '0;
      d_resp_q       <= 1'b0;
      l2_addr_q      <= '0;
      l2_read_q      <= 1'b0;
      l2_write_q     <= 1'b0;
      l2_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_is_write_q <= req_is_write_d;
      rbuf_q         <= rbuf_d;
      i_rdata_q      <= i_rdata_d;
      i_resp_q       <= i_resp_d;
      d_rdata_q      <= d_rdata_d;
      d_resp_q       <= d_resp_d;
      l2_addr_q      <= l2_addr_d;
      l2_read_q      <= l2_read_d;
      l2_write_q     <= l2_write_d;
      l2_wdata_q     <= l2_wdata_d;
    end
  end

  assign i_rdata  = i_rdata_q;
  assign i_resp   = i_resp_q;
  assign d_rdata  = d_rdata_q;
  assign d_resp   = d_resp_q;
  assign l2_addr  = l2_addr_q;
  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign l2_wdata = l2_wdata_q;

endmodule

// File: tb/tb_l2_cache_arbiter.sv
// Directed bench for l2_cache_arbiter: inputs driven and outputs sampled 1ns after each rising edge.
module tb_l2_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  i_addr, d_addr, l2_addr;
  logic         i_read, d_read, d_write;
  logic         i_resp, d_resp, l2_read, l2_write, l2_resp;
  logic [127:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [127:0] LINE_DB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] LINE_A5 = {16{8'hA5}};

  always #5 clk = ~clk;

  l2_cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    tick(); tick();
    total_cnt++; if ({i_resp, d_resp, l2_read, l2_write} !== 4'b0000) $display("FAIL reset_strobes: got %b exp 0000", {i_resp, d_resp, l2_read, l2_write}); else pass_cnt++;
    total_cnt++; if (l2_addr !== 16'h0) $display("FAIL reset_l2_addr: got %h exp 0000", l2_addr); else pass_cnt++;
    total_cnt++; if ({i_rdata, d_rdata, l2_wdata} !== 384'h0) $display("FAIL reset_data: i=%h d=%h w=%h exp 0", i_rdata, d_rdata, l2_wdata); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_i_read();
    i_read = 1'b1; i_addr = 16'h1236;
    tick();
    total_cnt++; if ({l2_read, l2_write} !== 2'b10) $display("FAIL i_strobe: rd/wr got %b exp 10", {l2_read, l2_write}); else pass_cnt++;
    total_cnt++; if (l2_addr !== 16'h1230) $display("FAIL i_l2_addr: got %h exp 1230", l2_addr); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      tick();
      total_cnt++; if (l2_read !== 1'b1 || i_resp !== 1'b0) $display("FAIL i_hold: l2_read=%b i_resp=%b exp 1/0", l2_read, i_resp); else pass_cnt++;
    end
    tick();
    l2_resp = 1'b1; l2_rdata = LINE_DB;
    tick();
    total_cnt++; if (i_resp !== 1'b1 || d_resp !== 1'b0) $display("FAIL i_resp: i=%b d=%b exp 1/0", i_resp, d_resp); else pass_cnt++;
    total_cnt++; if (i_rdata !== LINE_DB) $display("FAIL i_rdata: got %h exp %h", i_rdata, LINE_DB); else pass_cnt++;
    total_cnt++; if (l2_read !== 1'b0) $display("FAIL i_done_strobe: l2_read=%b exp 0", l2_read); else pass_cnt++;
    i_read = 1'b0; l2_resp = 1'b0;
    tick();
    total_cnt++; if (i_resp !== 1'b0 || l2_read !== 1'b0) $display("FAIL i_pulse: i_resp=%b l2_read=%b exp 0/0", i_resp, l2_read); else pass_cnt++;
  endtask

  task automatic test_d_write();
    d_write = 1'b1; d_addr = 16'h40A8; d_wdata = LINE_A5;
    tick();
    total_cnt++; if ({l2_read, l2_write} !== 2'b01) $display("FAIL dw_strobe: rd/wr got %b exp 01", {l2_read, l2_write}); else pass_cnt++;
    total_cnt++; if (l2_addr !== 16'h40A0) $display("FAIL dw_l2_addr: got %h exp 40a0", l2_addr); else pass_cnt++;
    total_cnt++; if (l2_wdata !== LINE_A5) $display("FAIL dw_wdata: got %h exp %h", l2_wdata, LINE_A5); else pass_cnt++;
    l2_resp = 1'b1; l2_rdata = 128'h77;
    tick();
    total_cnt++; if (d_resp !== 1'b1 || i_resp !== 1'b0) $display("FAIL dw_resp: d=%b i=%b exp 1/0", d_resp, i_resp); else pass_cnt++;
    total_cnt++; if (d_rdata !== 128'h77) $display("FAIL dw_rdata: got %h exp 77", d_rdata); else pass_cnt++;
    d_write = 1'b0; l2_resp = 1'b0;
    tick();
    total_cnt++; if (d_resp !== 1'b0 || l2_write !== 1'b0) $display("FAIL dw_pulse: d_resp=%b l2_write=%b exp 0/0", d_resp, l2_write); else pass_cnt++;
  endtask

  task automatic test_rw_both();
    d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0BCF; d_wdata = 128'h1234;
    tick();
    total_cnt++; if ({l2_read, l2_write} !== 2'b01) $display("FAIL rw_both_strobe: rd/wr got %b exp 01", {l2_read, l2_write}); else pass_cnt++;
    total_cnt++; if (l2_addr !== 16'h0BC0) $display("FAIL rw_both_addr: got %h exp 0bc0", l2_addr); else pass_cnt++;
    l2_resp = 1'b1;
    tick();
    d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_read = 1'b1; i_addr = 16'h2009; d_read = 1'b1; d_addr = 16'h3004;
    tick();
    total_cnt++; if (l2_addr !== 16'h3000 || l2_read !== 1'b1) $display("FAIL tie_first: addr=%h rd=%b exp 3000/1", l2_addr, l2_read); else pass_cnt++;
    l2_resp = 1'b1; l2_rdata = 128'hD1;
    tick();
    total_cnt++; if ({i_resp, d_resp} !== 2'b01 || d_rdata !== 128'hD1) $display("FAIL tie_d_resp: i/d=%b rdata=%h exp 01/d1", {i_resp, d_resp}, d_rdata); else pass_cnt++;
    d_read = 1'b0; l2_resp = 1'b0;
    tick();
    total_cnt++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) $display("FAIL tie_gap: rd/wr/ir/dr=%b exp 0000", {l2_read, l2_write, i_resp, d_resp}); else pass_cnt++;
    tick();
    total_cnt++; if (l2_addr !== 16'h2000 || l2_read !== 1'b1) $display("FAIL tie_second: addr=%h rd=%b exp 2000/1", l2_addr, l2_read); else pass_cnt++;
    l2_resp = 1'b1; l2_rdata = 128'hE2;
    tick();
    total_cnt++; if ({i_resp, d_resp} !== 2'b10 || i_rdata !== 128'hE2) $display("FAIL tie_i_resp: i/d=%b rdata=%h exp 10/e2", {i_resp, d_resp}, i_rdata); else pass_cnt++;
    i_read = 1'b0; l2_resp = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int ni, nd;
    logic [15:0] exp_i, exp_d;
    ni = 0; nd = 0;
    exp_i = 16'h1000; exp_d = 16'h8000;
    i_read = 1'b1; i_addr = exp_i | 16'h0003;
    d_write = 1'b1; d_addr = exp_d | 16'h000B; d_wdata = {8{16'hC000}};
    for (int t = 0; t < 6; t++) begin
      bit sd;
      sd = (t % 2 == 0);
      tick();
      total_cnt++; if (l2_addr !== (sd ? exp_d : exp_i) || {l2_read, l2_write} !== (sd ? 2'b01 : 2'b10))
        $display("FAIL b2b_grant%0d: addr=%h rd/wr=%b exp %h/%b", t, l2_addr, {l2_read, l2_write}, sd ? exp_d : exp_i, sd ? 2'b01 : 2'b10);
      else pass_cnt++;
      if (sd) begin
        total_cnt++; if (l2_wdata !== {8{16'(16'hC000 + nd)}}) $display("FAIL b2b_wdata%0d: got %h exp %h", t, l2_wdata, {8{16'(16'hC000 + nd)}}); else pass_cnt++;
      end
      l2_resp = 1'b1; l2_rdata = {4{32'(t + 100)}};
      tick();
      total_cnt++; if ({i_resp, d_resp} !== (sd ? 2'b01 : 2'b10) || (sd ? d_rdata : i_rdata) !== {4{32'(t + 100)}})
        $display("FAIL b2b_resp%0d: i/d=%b rdata=%h exp %b/%h", t, {i_resp, d_resp}, sd ? d_rdata : i_rdata, sd ? 2'b01 : 2'b10, {4{32'(t + 100)}});
      else pass_cnt++;
      l2_resp = 1'b0;
      if (sd) begin d_write = 1'b0; nd++; exp_d = 16'(16'h8000 + nd * 16'h0220); end
      else begin i_read = 1'b0; ni++; exp_i = 16'(16'h1000 + ni * 16'h0110); end
      tick();
      if (t + 2 < 6) begin
        if (sd) begin d_write = 1'b1; d_addr = exp_d | 16'h000B; d_wdata = {8{16'(16'hC000 + nd)}}; end
        else begin i_read = 1'b1; i_addr = exp_i | 16'h0003; end
      end
    end
    tick();
  endtask

  task automatic test_reset_abort();
    i_read = 1'b1; i_addr = 16'h5558;
    tick();
    total_cnt++; if (l2_read !== 1'b1 || l2_addr !== 16'h5550) $display("FAIL abort_serve: rd=%b addr=%h exp 1/5550", l2_read, l2_addr); else pass_cnt++;
    reset = 1'b1; i_read = 1'b0;
    tick();
    total_cnt++; if ({l2_read, i_resp} !== 2'b00) $display("FAIL abort_drop: rd/iresp=%b exp 00", {l2_read, i_resp}); else pass_cnt++;
    reset = 1'b0; l2_resp = 1'b1; l2_rdata = 128'hBAD;
    tick();
    total_cnt++; if ({i_resp, d_resp, l2_read, l2_write} !== 4'b0000) $display("FAIL abort_late_resp: %b exp 0000", {i_resp, d_resp, l2_read, l2_write}); else pass_cnt++;
    l2_resp = 1'b0;
    tick();
    total_cnt++; if (i_resp !== 1'b0) $display("FAIL abort_no_resp: i_resp=%b exp 0", i_resp); else pass_cnt++;
    i_read = 1'b1; i_addr = 16'h6664;
    tick();
    total_cnt++; if (l2_read !== 1'b1 || l2_addr !== 16'h6660) $display("FAIL abort_next: rd=%b addr=%h exp 1/6660", l2_read, l2_addr); else pass_cnt++;
    l2_resp = 1'b1; l2_rdata = 128'h66;
    tick();
    total_cnt++; if (i_resp !== 1'b1 || i_rdata !== 128'h66) $display("FAIL abort_next_resp: i_resp=%b rdata=%h exp 1/66", i_resp, i_rdata); else pass_cnt++;
    i_read = 1'b0; l2_resp = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    int resp_seen;
    resp_seen = 0;
    d_read = 1'b1; d_addr = 16'h1000;
    tick();
    total_cnt++; if (l2_addr !== 16'h1000 || l2_read !== 1'b1) $display("FAIL chg_start: addr=%h rd=%b exp 1000/1", l2_addr, l2_read); else pass_cnt++;
    d_addr = 16'h2000;
    tick();
    total_cnt++; if (l2_addr !== 16'h1000) $display("FAIL chg_hold1: addr=%h exp 1000", l2_addr); else pass_cnt++;
    tick();
    total_cnt++; if (l2_addr !== 16'h1000) $display("FAIL chg_hold2: addr=%h exp 1000", l2_addr); else pass_cnt++;
    l2_resp = 1'b1; l2_rdata = 128'h10;
    tick();
    if (d_resp === 1'b1) resp_seen++;
    d_read = 1'b0; l2_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (d_resp === 1'b1) resp_seen++;
    end
    total_cnt++; if (resp_seen != 1) $display("FAIL chg_resp_count: got %0d pulses exp 1", resp_seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_rw_both();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_addr_change();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
